// File: rtl/sram_1w1r_param.sv
// Parametrised 1W1R SRAM model: per-lane write masks, 1- or 2-cycle read pipeline with
// valid strobe, self-clearing init sequencer and a saturating collision counter.
// Optional build macro SRAM_BYPASS_EN: colliding reads return the merged (written) word.
module sram_1w1r_param #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 7,
  parameter int WMASK_WIDTH  = 4,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   csb0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_valid,
  output logic                   init_busy,
  output logic [CNT_WIDTH-1:0]   collision_cnt
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sram_1w1r_param: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH != WMASK_WIDTH * 8) begin : g_bad_width
    $error("sram_1w1r_param: DATA_WIDTH must equal WMASK_WIDTH*8");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   ptr_reg;
  logic                    init_busy_reg;
  logic [CNT_WIDTH-1:0]    collision_cnt_reg;
  logic                    rd_valid_reg;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   dout1_reg;
  logic                    dout1_valid_reg;

  logic                    live;
  logic                    wr_en;
  logic                    rd_en;
  logic                    clr_en;
  logic                    collision;
  logic [ADDR_WIDTH-1:0]   wr_addr;

  // Ports are live only in READY and never on a reset edge.
  assign live      = (state_reg == READY) && !rst;
  assign wr_en     = live && !csb0;
  assign rd_en     = live && !csb1;
  assign clr_en    = (state_reg == CLEAR) && !rst;
  assign collision = wr_en && rd_en && (addr0 == addr1) && (|wmask0);
  assign wr_addr   = clr_en ? ptr_reg : addr0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CLEAR;
      ptr_reg       <= '0;
      init_busy_reg <= 1'b1;
    end else if (state_reg == CLEAR) begin
      ptr_reg <= ptr_reg + 1'b1;
      if (&ptr_reg) begin
        state_reg     <= READY;
        init_busy_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_cnt_reg <= '0;
    end else if (collision && !(&collision_cnt_reg)) begin
      collision_cnt_reg <= collision_cnt_reg + 1'b1;
    end
  end

  // One byte-wide RAM per lane keeps masked writes a plain per-array write enable.
  for (genvar gi = 0; gi < WMASK_WIDTH; gi++) begin : g_lane
    logic [7:0] mem_lane [RAM_DEPTH];
    logic [7:0] rd_lane_reg;
    logic       lane_we;
    logic [7:0] lane_wdata;

    assign lane_we    = clr_en || (wr_en && wmask0[gi]);
    assign lane_wdata = clr_en ? 8'h00 : din0[8*gi +: 8];

    always_ff @(posedge clk) begin
      if (lane_we) begin
        mem_lane[wr_addr] <= lane_wdata;
      end
    end

    always_ff @(posedge clk) begin
      if (rd_en) begin
`ifdef SRAM_BYPASS_EN
        if (collision && wmask0[gi]) begin
          rd_lane_reg <= din0[8*gi +: 8];
        end else begin
          rd_lane_reg <= mem_lane[addr1];
        end
`else
        rd_lane_reg <= mem_lane[addr1];
`endif
      end
    end

    assign rd_word[8*gi +: 8] = rd_lane_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] mid_data_reg;
    logic                  mid_valid_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        mid_valid_reg   <= 1'b0;
        mid_data_reg    <= '0;
        dout1_valid_reg <= 1'b0;
        dout1_reg       <= '0;
      end else begin
        mid_valid_reg   <= rd_valid_reg;
        dout1_valid_reg <= mid_valid_reg;
        if (rd_valid_reg) begin
          mid_data_reg <= rd_word;
        end
        if (mid_valid_reg) begin
          dout1_reg <= mid_data_reg;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst) begin
        dout1_valid_reg <= 1'b0;
        dout1_reg       <= '0;
      end else begin
        dout1_valid_reg <= rd_valid_reg;
        if (rd_valid_reg) begin
          dout1_reg <= rd_word;
        end
      end
    end
  end

  assign dout1         = dout1_reg;
  assign dout1_valid   = dout1_valid_reg;
  assign init_busy     = init_busy_reg;
  assign collision_cnt = collision_cnt_reg;

endmodule

// File: tb/tb_sram_1w1r_param.sv
// Randomised and directed bench for sram_1w1r_param against an array/queue reference model.
module tb_sram_1w1r_param;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int MW    = 4;
  localparam int RL    = 2;
  localparam int CW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          csb0;
  logic [MW-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic          csb1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dout1;
  logic          dout1_valid;
  logic          init_busy;
  logic [CW-1:0] collision_cnt;

  always #5 clk = ~clk;

  sram_1w1r_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW),
    .READ_LATENCY(RL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1), .dout1_valid(dout1_valid),
    .init_busy(init_busy), .collision_cnt(collision_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: word array plus a queue of reads with their due edge.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] m_mem [DEPTH];
  rd_t           m_q[$];
  bit            m_busy  = 1'b1;
  int            m_clr   = 0;
  int            m_edge  = 0;
  int            m_cnt   = 0;
  logic [DW-1:0] m_last  = '0;
  bit            m_valid = 1'b0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [MW-1:0] mask);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < MW; i++) begin
      if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  task automatic model_edge();
    m_edge++;
    if (rst) begin
      m_busy  = 1'b1;
      m_clr   = 0;
      m_q.delete();
      m_cnt   = 0;
      m_last  = '0;
      m_valid = 1'b0;
      return;
    end
    if (m_busy) begin
      m_clr++;
      if (m_clr == DEPTH) begin
        m_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      bit coll;
      coll = !csb0 && !csb1 && (addr0 == addr1) && (wmask0 != 0);
      if (!csb1) begin
        rd_t r;
        r.due  = m_edge + RL;
        r.data = m_mem[addr1];
`ifdef SRAM_BYPASS_EN
        if (coll) r.data = merge(m_mem[addr1], din0, wmask0);
`endif
        m_q.push_back(r);
      end
      if (!csb0) m_mem[addr0] = merge(m_mem[addr0], din0, wmask0);
      if (coll && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    m_valid = 1'b0;
    if (m_q.size() > 0 && m_q[0].due == m_edge) begin
      m_valid = 1'b1;
      m_last  = m_q[0].data;
      void'(m_q.pop_front());
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_value("valid", dout1_valid, m_valid);
    check_value("dout1", dout1, m_last);
    check_value("init_busy", init_busy, m_busy);
    check_value("coll_cnt", collision_cnt, m_cnt);
  endtask

  task automatic idle();
    csb0 = 1'b1;
    csb1 = 1'b1;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    csb0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic set_rd(input logic [AW-1:0] a);
    csb1 = 1'b0; addr1 = a;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (init_busy && n < 200);
    check_value("init_len", n, DEPTH);
  endtask

  logic [5:0]    vbits;
  logic [DW-1:0] dd [6];

  initial begin
    rst = 1'b1; csb0 = 1'b1; csb1 = 1'b1; wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
    repeat (3) cycle();
    check_value("rst_busy", init_busy, 1);
    check_value("rst_dout", dout1, 0);
    check_value("rst_cnt", collision_cnt, 0);

    rst = 1'b0;
    wait_init();

    // Every word must read back as zero after init.
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a[AW-1:0]);
      cycle();
    end
    idle();
    repeat (RL) cycle();

    // Masked write merge.
    set_wr(5, 32'hAABBCCDD, 4'hF); cycle();
    set_wr(5, 32'h11223344, 4'h5); cycle();
    csb0 = 1'b1; set_rd(5); cycle();
    idle();
    repeat (RL) cycle();
    check_value("mask_merge", dout1, 32'hAA22CC44);
    check_value("mask_valid", dout1_valid, 1);

    // Latency and ordering of back-to-back reads.
    set_wr(1, 32'h101, 4'hF); cycle();
    set_wr(2, 32'h202, 4'hF); cycle();
    set_wr(3, 32'h303, 4'hF); cycle();
    idle();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) set_rd(i[AW-1:0] + 1'b1);
      else idle();
      cycle();
      vbits[i] = dout1_valid;
      dd[i]    = dout1;
    end
    check_value("lat_valid", vbits, 6'b011100);
    check_value("lat_d0", dd[2], 32'h101);
    check_value("lat_d1", dd[3], 32'h202);
    check_value("lat_d2", dd[4], 32'h303);

    // Collision on a cleared word.
    set_wr(7, 32'hFFFFFFFF, 4'h3); set_rd(7); cycle();
    idle();
    repeat (RL) cycle();
`ifdef SRAM_BYPASS_EN
    check_value("coll_data", dout1, 32'h0000FFFF);
`else
    check_value("coll_data", dout1, 32'h00000000);
`endif
    check_value("coll_cnt1", collision_cnt, 1);

    // Reset with a read in flight, then reset again mid-clear at ptr 9.
    set_rd(2); cycle();
    idle(); rst = 1'b1; cycle();
    rst = 1'b0;
    repeat (RL + 1) cycle();
    check_value("drop_valid", dout1_valid, 0);
    repeat (9 - RL - 1) cycle();
    rst = 1'b1; cycle();
    rst = 1'b0;
    wait_init();

    // Counter saturation.
    for (int i = 0; i < 20; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, DEPTH - 1));
      set_wr(a, $urandom, MW'($urandom_range(1, (1 << MW) - 1)));
      set_rd(a);
      cycle();
    end
    idle(); cycle();
    check_value("sat_cnt", collision_cnt, 15);

    // Random traffic on a narrow address range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      csb0   = 1'($urandom_range(0, 1));
      csb1   = 1'($urandom_range(0, 1));
      addr0  = AW'($urandom_range(0, 3));
      addr1  = AW'($urandom_range(0, 3));
      wmask0 = MW'($urandom);
      din0   = $urandom;
      cycle();
    end
    idle();
    repeat (RL + 1) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
